// File: rtl/simplez_pkg.sv
// Shared types and helpers for the Simplez UART blocks.
package simplez_pkg;

  // Transmitter frame phases.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  // Parity selection codes.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Wide enough to count up to 9 data bits or 2 stop bits.
  localparam int BIT_CNT_W = 4;

  // Ceiling log2 for sizing counters and pointers (clog2(1) = 0).
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/simplez_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// Writes while full and reads while empty are ignored.
module simplez_fifo
  import simplez_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("simplez_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  // Flags are the registered view, so acceptance never depends on a same-cycle pop.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign dout    = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Next pointers, occupancy and flags; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; a flushed FIFO never reads an entry before it is rewritten.
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/simplez_uart_tx.sv
// Buffered UART transmitter: FIFO-fed, baud-timed shifter with optional
// parity and one or two stop bits. tx comes straight from a flop.
module simplez_uart_tx
  import simplez_pkg::*;
#(
  parameter int BAUD_DIV   = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 clr_ovf,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf
);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("simplez_uart_tx: BAUD_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("simplez_uart_tx: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("simplez_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("simplez_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int                   BW        = clog2(BAUD_DIV);
  localparam logic [BW-1:0]        BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
  localparam bit                   HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic                 ODD_PAR   = (PARITY == PAR_ODD);

  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;
  logic                   pop;
  logic                   baud_end;
  logic [DATA_BITS-1:0]   head;
  logic                   fifo_full;
  logic                   fifo_empty;

  simplez_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr),
    .pop  (pop),
    .din  (data),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign ovf      = ovf_q;

  // Frame sequencing: tx_d is the line level for the phase being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_CNT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Parity is fixed from the popped word, before any shifting.
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ ODD_PAR;
    end
  end

  // Sticky overflow: a dropped write beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr && fifo_full) ovf_d = 1'b1;
    else if (clr_ovf)    ovf_d = 1'b0;
  end

  // Transmitter state register; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/simplez_uart_tx.md
Name: simplez_uart_tx

Overview:
Parametrised buffered UART transmitter for the Simplez I/O space, replacing the fixed 8N1 unbuffered tx path. The CPU writes characters with a one-cycle strobe into a small FIFO, and a baud-timed shifter serialises them onto tx. Word length, parity, stop bits, baud divisor and FIFO depth are configurable. Status flags let firmware poll before writing instead of relying on WAIT_DELAY stalls.

Parameters:
BAUD_DIV, 104, clock cycles per bit (≥2); 104 = 115200 baud at 12 MHz
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, entries, power of two ≥2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr  in  1  write strobe, one cycle per character
data  in  DATA_BITS  character, sampled when wr=1
clr_ovf  in  1  clears sticky overflow flag
tx  out  1  serial line, idle high
busy  out  1  frame in progress
full  out  1  FIFO holds FIFO_DEPTH entries
empty  out  1  FIFO holds 0 entries
ovf  out  1  sticky: write dropped while full

Behaviour:
- One clock; reset is asynchronous and active-high on rst; all state on clk rising edge.
- Reset values: tx=1, busy=0, full=0, empty=1, ovf=0. The FIFO is flushed, the FSM goes to IDLE, and the baud counter goes to 0.
- Reset asserted mid-frame: tx returns high immediately (asynchronously) and the partial frame is abandoned.
- Write acceptance:
  - A write is accepted iff wr=1 and the registered full=0.
  - A pop in the same cycle does not rescue a write attempted while full.
  - A rejected write sets ovf=1.
- ovf handling:
  - ovf is cleared by clr_ovf=1.
  - If clr_ovf=1 coincides with a rejected write, the set wins.
- full and empty are registered and reflect the FIFO count after each edge.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE with empty=0 at edge E: pop the head into the shift register, go to START, tx=0 from E.
  - Single-write latency: write sampled at E0, tx falls at E1.
  - Each bit lasts exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1 and restarts on every state/bit change.
  - DATA: shift LSB first, DATA_BITS bits.
  - PAR: only if PARITY≠0.
    - Even parity bit = XOR of the data bits.
    - Odd parity bit = inverted XOR.
    - Parity is computed from the popped word, not the live shift register.
  - STOP: tx=1 for STOP_BITS×BAUD_DIV cycles.
  - End of STOP with empty=0: pop and enter START on the same edge (no idle gap). With empty=1: go to IDLE.
- Frame length = (1+DATA_BITS+(PARITY≠0)+STOP_BITS)×BAUD_DIV cycles.
- busy=1 in every state except IDLE.
- tx is driven from a register (glitch-free).
- FIFO wraps its read/write pointers modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Illegal parameters (PARITY>2, STOP_BITS∉{1,2}, BAUD_DIV<2, depth not a power of two) are caught at elaboration.

Decomposition:
- Package simplez_pkg:
  - FSM state encoding (IDLE/START/DATA/PAR/STOP)
  - Parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - Helper function for clog2
- Sub-module simplez_fifo:
  - Synchronous single-clock FIFO, parametrised by WIDTH and DEPTH
  - Ports: push/pop/din/dout/full/empty, async active-high rst
  - Reused later for an RX path.
- The top level holds the baud counter, bit counter, shift register and FSM.

Test Plan:
1. BAUD_DIV=4, 8N1, write 0x55 at cycle 0 → tx=0 over cycles 1–4. Data bits 1,0,1,0,1,0,1,0 follow, 4 cycles each, then a stop high. busy is high for exactly 40 cycles, then empty=1 and busy=0.
2. PARITY=1, write 0x07 → parity bit=1. With PARITY=2, the same write gives parity bit=0. Frame length is 44 cycles at BAUD_DIV=4.
3. FIFO_DEPTH=4, wr high for 6 consecutive cycles (0x01..0x06) → writes 1–5 accepted, full=1 after the 5th, 0x06 dropped, ovf=1. Line output is 0x01..0x05 back-to-back, with the next start bit immediately after each stop bit. A clr_ovf pulse then gives ovf=0.
4. STOP_BITS=2, two queued bytes → tx stays high for 2×BAUD_DIV cycles between frames, with no extra idle cycle.
5. Assert rst at mid-data bit of the second of three queued frames → tx=1 and busy=0 asynchronously, empty=1, ovf=0. A write after release restarts cleanly with a start bit one cycle later.
6. Simultaneous wr with full=1 and a stop-bit-end pop → write rejected, ovf=1, count ends at DEPTH-1.
